wait_event_checker: RTL and testbench

- Bench-side event monitor. Waits for a rising edge (WTR) or falling edge (WTF) on one of WAIT_SIZE monitored signals, bounded by a timeout in picoseconds.
- Reports completion with a one-cycle done pulse and a timeout flag.
- Sits between the command sequencer (which drives the request fields) and the DUT signals under observation. Timing reference comes from the clock generator.

---
 rtl/wait_event_checker.sv | 150 +++++++++++++++
 tb/tb_wait_event_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wait_event_checker.sv
// Edge/timeout event monitor: waits for a rise or fall on one selected signal,
// bounded by a picosecond timeout. Optional input synchronizer: WAIT_EVENT_SYNC_EN.
module wait_event_checker #(
  parameter int WAIT_SIZE  = 5,
  parameter int WAIT_WIDTH = 1,
  parameter int CLK_PERIOD = 10000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wait_en,
  input  logic                            sel_wtr_wtf,
  input  logic [4:0]                      wait_sel,
  input  logic [31:0]                     max_timeout,
  input  logic [WAIT_SIZE*WAIT_WIDTH-1:0] wait_signals,
  output logic                            wait_done,
  output logic                            wait_timeout,
  output logic                            busy
);

  // Handshake: wait_en is a request sampled only in S_IDLE (no queueing);
  // busy marks an accepted wait in progress; wait_done is a single-cycle
  // completion pulse qualifying wait_timeout.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                 state;
  logic [WAIT_SIZE-1:0]   lvl_raw;
  logic [WAIT_SIZE-1:0]   lvl_cur;
  logic [WAIT_SIZE-1:0]   lvl_q;
  logic [31:0]            cur_pad;
  logic [31:0]            prev_pad;
  logic                   rise_q;
  logic [4:0]             sel_q;
  logic [31:0]            max_q;
  logic [39:0]            acc;
  logic [40:0]            acc_sum;
  logic [39:0]            acc_inc;
  logic                   sel_cur;
  logic                   sel_prev;
  logic                   edge_hit;
  logic                   expired;
  logic                   bad_sel;

  // Only a definite 1 counts; X/Z bits read as 0.
  always_comb begin
    lvl_raw = '0;
    for (int i = 0; i < WAIT_SIZE; i++) begin
      for (int b = 0; b < WAIT_WIDTH; b++) begin
        if (wait_signals[i*WAIT_WIDTH+b] === 1'b1) lvl_raw[i] = 1'b1;
      end
    end
  end

`ifdef WAIT_EVENT_SYNC_EN
  logic [WAIT_SIZE-1:0] sync_1;
  logic [WAIT_SIZE-1:0] sync_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= lvl_raw;
      sync_2 <= sync_1;
    end
  end

  assign lvl_cur = sync_2;
`else
  assign lvl_cur = lvl_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_q <= '0;
    else     lvl_q <= lvl_cur;
  end

  // Pad to 32 so any 5-bit index is in range; out-of-range selects never reach S_WAIT.
  assign cur_pad  = 32'(lvl_cur);
  assign prev_pad = 32'(lvl_q);
  assign sel_cur  = cur_pad[sel_q];
  assign sel_prev = prev_pad[sel_q];
  assign edge_hit = rise_q ? (!sel_prev && sel_cur) : (sel_prev && !sel_cur);

  assign acc_sum  = {1'b0, acc} + 41'(CLK_PERIOD);
  assign acc_inc  = acc_sum[40] ? '1 : acc_sum[39:0];
  assign expired  = (max_q != 32'd0) && (acc_inc >= {8'd0, max_q});
  assign bad_sel  = {1'b0, wait_sel} >= 6'(WAIT_SIZE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      wait_done    <= 1'b0;
      wait_timeout <= 1'b0;
      busy         <= 1'b0;
      acc          <= '0;
      rise_q       <= 1'b0;
      sel_q        <= '0;
      max_q        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_done    <= 1'b0;
          wait_timeout <= 1'b0;
          if (wait_en) begin
            rise_q <= sel_wtr_wtf;
            sel_q  <= wait_sel;
            max_q  <= max_timeout;
            acc    <= '0;
            if (bad_sel) begin
              state        <= S_DONE;
              wait_done    <= 1'b1;
              wait_timeout <= 1'b1;
            end else begin
              state <= S_WAIT;
              busy  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          acc <= acc_inc;
          // An edge coinciding with expiry takes priority over the timeout.
          if (edge_hit) begin
            state        <= S_DONE;
            wait_done    <= 1'b1;
            wait_timeout <= 1'b0;
            busy         <= 1'b0;
          end else if (expired) begin
            state        <= S_DONE;
            wait_done    <= 1'b1;
            wait_timeout <= 1'b1;
            busy         <= 1'b0;
          end
        end
        S_DONE: begin
          state        <= S_IDLE;
          wait_done    <= 1'b0;
          wait_timeout <= 1'b0;
          busy         <= 1'b0;
        end
        default: begin
          state        <= S_IDLE;
          wait_done    <= 1'b0;
          wait_timeout <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wait_event_checker.sv
// Directed bench for wait_event_checker (default build, 1-cycle edge latency).
`timescale 1ns/1ps
module tb_wait_event_checker;

  logic        clk;
  logic        rst;
  logic        wait_en;
  logic        sel_wtr_wtf;
  logic [4:0]  wait_sel;
  logic [31:0] max_timeout;
  logic [4:0]  sigs;
  logic        wait_done;
  logic        wait_timeout;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n;
  int busy_cnt;

  wait_event_checker #(.WAIT_SIZE(5), .WAIT_WIDTH(1), .CLK_PERIOD(10000)) dut (
    .clk          (clk),
    .rst          (rst),
    .wait_en      (wait_en),
    .sel_wtr_wtf  (sel_wtr_wtf),
    .wait_sel     (wait_sel),
    .max_timeout  (max_timeout),
    .wait_signals (sigs),
    .wait_done    (wait_done),
    .wait_timeout (wait_timeout),
    .busy         (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic rise, input logic [4:0] sel, input logic [31:0] tmo);
    sel_wtr_wtf = rise;
    wait_sel    = sel;
    max_timeout = tmo;
    wait_en     = 1'b1;
    step();
    wait_en     = 1'b0;
  endtask

  // Steps until wait_done, bounded; returns cycles taken (0 = never seen).
  task automatic wait_for_done(input int budget, output int cycles);
    cycles = 0;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (wait_done === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; wait_en = 1'b0; sel_wtr_wtf = 1'b0; wait_sel = '0; max_timeout = '0; sigs = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", wait_done, 0);
    check("rst_timeout", wait_timeout, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // Rise on signal 0, edge driven 7 cycles after acceptance
    start(1'b1, 5'd0, 32'd0);
    check("t1_busy_accept", busy, 1);
    busy_cnt = 1;
    repeat (6) begin
      step();
      if (busy) busy_cnt++;
      check("t1_no_done", wait_done, 0);
    end
    sigs[0] = 1'b1;
    step();
    check("t1_done", wait_done, 1);
    check("t1_timeout", wait_timeout, 0);
    check("t1_busy_at_done", busy, 0);
    check("t1_busy_cycles", busy_cnt, 7);
    step();
    check("t1_pulse_width", wait_done, 0);

    // Fall timeout on signal 2 held low: 5 WAIT cycles
    sigs = '0;
    step();
    start(1'b0, 5'd2, 32'd50000);
    wait_for_done(20, n);
    check("t2_cycles", n, 5);
    check("t2_timeout", wait_timeout, 1);
    step();
    check("t2_pulse_width", wait_done, 0);

    // Rise lands in the expiry cycle: edge wins
    start(1'b1, 5'd1, 32'd30000);
    step();
    check("t3_no_done_1", wait_done, 0);
    step();
    check("t3_no_done_2", wait_done, 0);
    sigs[1] = 1'b1;
    step();
    check("t3_done", wait_done, 1);
    check("t3_timeout", wait_timeout, 0);
    step();

    // Non-multiple timeout: 25000 expires on the 3rd WAIT cycle
    start(1'b1, 5'd1, 32'd25000);
    wait_for_done(20, n);
    check("t3b_cycles", n, 3);
    check("t3b_timeout", wait_timeout, 1);
    step();

    // Bad index
    start(1'b1, 5'd5, 32'd0);
    check("t4_done", wait_done, 1);
    check("t4_timeout", wait_timeout, 1);
    check("t4_busy", busy, 0);
    step();
    check("t4_pulse_width", wait_done, 0);

    // Back-to-back with wait_en held high
    sel_wtr_wtf = 1'b1; wait_sel = 5'd31; max_timeout = '0; wait_en = 1'b1;
    step();
    check("b2b_done_1", wait_done, 1);
    step();
    check("b2b_gap", wait_done, 0);
    step();
    check("b2b_done_2", wait_done, 1);
    check("b2b_timeout_2", wait_timeout, 1);
    wait_en = 1'b0;
    step();
    check("b2b_idle", wait_done, 0);

    // Reset mid-wait aborts without a done pulse
    start(1'b1, 5'd0, 32'd0);
    sigs[0] = 1'b0;
    step();
    step();
    check("t5_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_busy_on_rst", busy, 0);
    check("t5_done_on_rst", wait_done, 0);
    #2 rst = 1'b0;
    sigs[0] = 1'b1;
    n = 0;
    repeat (4) begin
      step();
      if (wait_done) n++;
    end
    check("t5_no_done_after", n, 0);
    check("t5_busy_after", busy, 0);

    // Ignored request and capture isolation
    sigs[3] = 1'b1;
    sigs[4] = 1'b0;
    step();
    start(1'b0, 5'd3, 32'd0);
    wait_en = 1'b1; sel_wtr_wtf = 1'b1; wait_sel = 5'd4; max_timeout = 32'd10000;
    sigs[4] = 1'b1;
    step();
    check("t6_no_redirect", wait_done, 0);
    check("t6_still_busy", busy, 1);
    wait_en = 1'b0;
    n = 0;
    repeat (3) begin
      step();
      if (wait_done) n++;
    end
    check("t6_no_done", n, 0);
    sigs[3] = 1'b0;
    step();
    check("t6_done", wait_done, 1);
    check("t6_timeout", wait_timeout, 0);
    step();

    // Edge in the acceptance cycle is not counted
    sigs[1] = 1'b0;
    step();
    sigs[1] = 1'b1;
    start(1'b1, 5'd1, 32'd0);
    n = 0;
    repeat (3) begin
      step();
      if (wait_done) n++;
    end
    check("t7_accept_edge_ignored", n, 0);
    sigs[1] = 1'b0;
    step();
    check("t7_fall_ignored", wait_done, 0);
    sigs[1] = 1'b1;
    step();
    check("t7_done", wait_done, 1);
    check("t7_timeout", wait_timeout, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
